muladd2_dotacc: RTL and testbench
=================================

MULADD2_DOTACC -- requirements
Module: muladd2_dotacc

Interface
REQ-001 Parameter NPAIR, default 4, meaning: 2-bit activation/weight pairs per beat (2*NPAIR products per beat).
REQ-002 Parameter ACC_W, default 20, meaning: signed accumulator and result width.
REQ-003 Parameter CNT_W, default 16, meaning: beat-counter width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  beat valid.
REQ-007 in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-008 act_code  input  4*NPAIR  activation codes, product k at bits [2k+1:2k].
REQ-009 wgt_code  input  4*NPAIR  weight codes, same packing as act_code.
REQ-010 act_zero  input  2*NPAIR  per-activation zero flag, bit k forces activation k to 0.
REQ-011 in_last  input  1  final beat of the current dot product.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-014 out_data  output  ACC_W  signed dot-product result.
REQ-015 out_beats  output  CNT_W  beats accumulated into out_data.
REQ-016 out_ovf  output  1  accumulator saturated during this result.

Function
REQ-017 Decode: 00->-3, 01->-1, 10->+1, 11->+3; act_zero[k]=1 -> activation k = 0 regardless of code.
REQ-018 Beat sum S = sum over k of act_k*wgt_k; signed, range +/-9*2*NPAIR; no DSP inference; products come from case-decoded logic.
REQ-019 Stage 1: on acceptance, S, in_last registered next edge.
REQ-020 Stage 2: cycle after stage-1 load, acc <= acc + S, beat count +1 (count saturates at 2^CNT_W-1).
REQ-021 FSM states ACC, FLUSH, HOLD; reset state ACC.
REQ-022 ACC: in_ready=1; accepted beat with in_last=1 -> FLUSH; otherwise stay ACC.
REQ-023 FLUSH: in_ready=0; final stage-2 add completes, result registers loaded with final acc/count/ovf -> HOLD.
REQ-024 HOLD: out_valid=1, in_ready=0; out_data/out_beats/out_ovf stable until out_ready=1; on handshake acc, count, ovf clear -> ACC.
REQ-025 Latency: in_last accepted at edge T -> out_valid high from edge T+2; next beat accepted no earlier than the edge after the output handshake.
REQ-026 out_ready=1 on entering HOLD -> handshake in that first HOLD cycle; out_valid high exactly one cycle.
REQ-027 in_valid=0 in ACC leaves acc unchanged; bubbles between beats allowed.
REQ-028 Single-beat vector (in_last on first beat) yields out_beats=1.
REQ-029 ACC_W SHALL be at least ceil(log2(18*NPAIR+1))+2; smaller values rejected at elaboration.
REQ-030 in_ready is a registered-state decode, with no combinational path from in_valid or out_ready.

Reset
REQ-031 rst=1 asynchronously: FSM->ACC, acc=0, count=0, stage-1 cleared, out_valid=0, out_data=0, out_beats=0, out_ovf=0; in_ready=1 from first edge after deassertion.
REQ-032 Reset mid-vector or in HOLD discards the partial or held result; no output produced for it.

Configuration
REQ-033 Macro MULADD_DOTACC_SAT_EN defined: stage-2 add clamps to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; out_ovf set sticky for that result on any clamp.
REQ-034 MULADD_DOTACC_SAT_EN undefined: two's-complement wrap at ACC_W bits; out_ovf tied 0.

Verification
REQ-035 NPAIR=4, all codes 11, act_zero=0, 3 beats with in_last on beat 3 accepted at T -> out_valid at T+2, out_data=216, out_beats=3, out_ovf=0.
REQ-036 act_code=00 all, wgt_code=11 all, act_zero=8'hFF, 1 beat -> out_data=0, out_beats=1.
REQ-037 Mixed beat: act codes {00,01,10,11} x2, wgt all 11 -> S=2*(-9-3+3+9)=0; second beat act all 00, wgt all 11 -> S=-72, out_data=-72.
REQ-038 Result held with out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout, no beat accepted; out_ready=1 -> ACC next cycle.
REQ-039 ACC_W=9, 4 beats of S=72: with SAT_EN out_data=255, out_ovf=1; without it out_data=288-512=-224, out_ovf=0.
REQ-040 rst pulsed after 2 of 3 beats -> no out_valid; a fresh 1-beat vector of S=72 yields out_data=72, out_beats=1.

Source files
------------

// File: rtl/muladd2_dotacc.sv
// ============================================================================
// Module      : muladd2_dotacc
// Description : Streaming 2-bit x 2-bit dot-product accumulator with a result
//               hold buffer. Optional macro MULADD_DOTACC_SAT_EN selects a
//               saturating accumulator; otherwise the accumulator wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muladd2_dotacc #(
    parameter int NPAIR = 4,
    parameter int ACC_W = 20,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NPAIR-1:0]   act_code,
    input  logic [4*NPAIR-1:0]   wgt_code,
    input  logic [2*NPAIR-1:0]   act_zero,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [CNT_W-1:0]     out_beats,
    output logic                 out_ovf
);

    localparam int c_NPROD     = 2 * NPAIR;
    localparam int c_SUM_W     = $clog2(18 * NPAIR + 1) + 1;
    localparam int c_MIN_ACC_W = c_SUM_W + 1;

    if (ACC_W < c_MIN_ACC_W) begin : g_acc_w_check
        $error("muladd2_dotacc: ACC_W too small for NPAIR");
    end

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic signed [c_SUM_W-1:0]  r_s1_sum;
    logic signed [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_out_valid;
    logic [ACC_W-1:0]           r_out_data;
    logic [CNT_W-1:0]           r_out_beats;

    logic [c_NPROD-1:0][c_SUM_W-1:0] w_prod_ext;
    logic signed [c_SUM_W-1:0]  w_beat_sum;
    logic signed [ACC_W-1:0]    w_s1_ext;
    logic signed [ACC_W:0]      w_acc_wide;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic                       w_accept;

    // Each product is one of {0, +/-1, +/-3, +/-9}, decoded from the code pair.
    for (genvar k = 0; k < c_NPROD; k++) begin : g_prod
        logic signed [4:0] w_p;
        always_comb begin
            w_p = '0;
            case ({act_code[2*k +: 2], wgt_code[2*k +: 2]})
                4'b0000: w_p = 5'sd9;
                4'b0001: w_p = 5'sd3;
                4'b0010: w_p = -5'sd3;
                4'b0011: w_p = -5'sd9;
                4'b0100: w_p = 5'sd3;
                4'b0101: w_p = 5'sd1;
                4'b0110: w_p = -5'sd1;
                4'b0111: w_p = -5'sd3;
                4'b1000: w_p = -5'sd3;
                4'b1001: w_p = -5'sd1;
                4'b1010: w_p = 5'sd1;
                4'b1011: w_p = 5'sd3;
                4'b1100: w_p = -5'sd9;
                4'b1101: w_p = -5'sd3;
                4'b1110: w_p = 5'sd3;
                4'b1111: w_p = 5'sd9;
                default: w_p = '0;
            endcase
            if (act_zero[k]) begin
                w_p = '0;
            end
        end
        assign w_prod_ext[k] = {{(c_SUM_W-5){w_p[4]}}, w_p};
    end

    always_comb begin
        w_beat_sum = '0;
        for (int k = 0; k < c_NPROD; k++) begin
            w_beat_sum = w_beat_sum + $signed(w_prod_ext[k]);
        end
    end

    assign w_s1_ext   = {{(ACC_W-c_SUM_W){r_s1_sum[c_SUM_W-1]}}, r_s1_sum};
    assign w_acc_wide = {r_acc[ACC_W-1], r_acc} + {w_s1_ext[ACC_W-1], w_s1_ext};

`ifdef MULADD_DOTACC_SAT_EN
    logic w_clamp;
    logic r_ovf;
    logic r_out_ovf;

    // Top two bits of the widened sum disagree exactly when ACC_W overflowed.
    assign w_clamp    = w_acc_wide[ACC_W] ^ w_acc_wide[ACC_W-1];
    assign w_acc_next = !w_clamp ? w_acc_wide[ACC_W-1:0] :
                        w_acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                            {1'b0, {(ACC_W-1){1'b1}}};
    assign out_ovf    = r_out_ovf;
`else
    assign w_acc_next = r_acc + w_s1_ext;
    assign out_ovf    = 1'b0;
`endif

    assign in_ready  = (r_state == ST_ACC);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_sum    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
`ifdef MULADD_DOTACC_SAT_EN
            r_ovf       <= 1'b0;
            r_out_ovf   <= 1'b0;
`endif
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sum  <= w_beat_sum;
                r_s1_last <= in_last;
            end

            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
`ifdef MULADD_DOTACC_SAT_EN
                r_ovf <= r_ovf | w_clamp;
`endif
            end

            case (r_state)
                ST_ACC: begin
                    if (w_accept && in_last) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Wait until the last beat's stage-2 add has landed in r_acc.
                    if (!(r_s1_valid && r_s1_last)) begin
                        r_out_data  <= r_acc;
                        r_out_beats <= r_cnt;
`ifdef MULADD_DOTACC_SAT_EN
                        r_out_ovf   <= r_ovf;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
`ifdef MULADD_DOTACC_SAT_EN
                        r_ovf       <= 1'b0;
`endif
                        r_state     <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muladd2_dotacc.sv
// ============================================================================
// Module      : tb_muladd2_dotacc
// Description : Randomized self-checking bench for muladd2_dotacc against an
//               arithmetic reference model (honours MULADD_DOTACC_SAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muladd2_dotacc;

    localparam int NPAIR = 4;
    localparam int AW    = 9;
    localparam int CW    = 4;
    localparam int AMAX  = 2**(AW-1) - 1;
    localparam int AMIN  = -(2**(AW-1));
    localparam int CMAX  = 2**CW - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4*NPAIR-1:0] act_code = '0;
    logic [4*NPAIR-1:0] wgt_code = '0;
    logic [2*NPAIR-1:0] act_zero = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [AW-1:0]      out_data;
    logic [CW-1:0]      out_beats;
    logic               out_ovf;

    muladd2_dotacc #(.NPAIR(NPAIR), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_code  (act_code),
        .wgt_code  (wgt_code),
        .act_zero  (act_zero),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_acc   = 0;
    int m_beats = 0;
    int m_ovf   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Activation/weight value is 2*code-3; a zero flag removes the product.
    function automatic int beat_sum(input logic [15:0] a, input logic [15:0] w,
                                    input logic [7:0] z);
        int s = 0;
        for (int k = 0; k < 8; k++) begin
            if (!z[k]) begin
                s += (2*int'(a[2*k +: 2]) - 3) * (2*int'(w[2*k +: 2]) - 3);
            end
        end
        return s;
    endfunction

    task automatic model_add(input int s);
        int t;
        t = m_acc + s;
`ifdef MULADD_DOTACC_SAT_EN
        if (t > AMAX) begin
            t = AMAX;
            m_ovf = 1;
        end else if (t < AMIN) begin
            t = AMIN;
            m_ovf = 1;
        end
`else
        t = (t - AMIN) % (2**AW);
        if (t < 0) t += 2**AW;
        t += AMIN;
`endif
        m_acc = t;
        if (m_beats < CMAX) m_beats++;
    endtask

    task automatic model_clear();
        m_acc   = 0;
        m_beats = 0;
        m_ovf   = 0;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] w,
                             input logic [7:0] z, input logic last,
                             input int bubbles);
        int t;
        t = 0;
        repeat (bubbles) begin
            in_valid = 1'b0;
            act_code = 16'($urandom);
            @(posedge clk); #1;
        end
        act_code = a;
        wgt_code = w;
        act_zero = z;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("beat_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_add(beat_sum(a, w, z));
    endtask

    // Entered at #1 after the edge that accepted the last beat.
    task automatic finish_vec(input string tag, input int hold);
        int exp_ovf;
`ifdef MULADD_DOTACC_SAT_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = 0;
`endif
        if (hold == 0) out_ready = 1'b1;
        check({tag, "_valid_t0"}, int'(out_valid), 0);
        @(posedge clk); #1;
        check({tag, "_valid_t1"}, int'(out_valid), 0);
        @(posedge clk); #1;
        check({tag, "_valid_t2"}, int'(out_valid), 1);
        check({tag, "_data"},  int'($signed(out_data)), m_acc);
        check({tag, "_beats"}, int'(out_beats), m_beats);
        check({tag, "_ovf"},   int'(out_ovf), exp_ovf);
        check({tag, "_rdy_hold"}, int'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_last  = 1'($urandom);
            act_code = 16'($urandom);
            wgt_code = 16'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_data"},  int'($signed(out_data)), m_acc);
            check({tag, "_hold_rdy"},   int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_done"}, int'(out_valid), 0);
        check({tag, "_rdy_done"},   int'(in_ready), 1);
        model_clear();
    endtask

    task automatic rand_vec(input string tag, input int nbeats);
        logic [15:0] a;
        logic [15:0] w;
        logic [7:0]  z;
        for (int b = 0; b < nbeats; b++) begin
            a = 16'($urandom);
            w = 16'($urandom);
            z = 8'($urandom) & 8'($urandom) & 8'($urandom);
            send_beat(a, w, z, (b == nbeats - 1), $urandom_range(0, 2));
        end
        finish_vec(tag, $urandom_range(0, 4));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'($signed(out_data)), 0);
        check("rst_out_beats", int'(out_beats), 0);
        check("rst_out_ovf",   int'(out_ovf), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1);

        // All codes 11: S = 72 per beat, three beats.
        for (int b = 0; b < 3; b++) send_beat(16'hFFFF, 16'hFFFF, 8'h00, (b == 2), 0);
        finish_vec("all_ones", 0);

        // Zeroed activations with single beat.
        send_beat(16'h0000, 16'hFFFF, 8'hFF, 1'b1, 0);
        finish_vec("zeroed", 1);

        // Mixed codes cancel, then all -3 activations give -72.
        send_beat(16'b11_10_01_00_11_10_01_00, 16'hFFFF, 8'h00, 1'b0, 0);
        send_beat(16'h0000, 16'hFFFF, 8'h00, 1'b1, 1);
        finish_vec("mixed", 5);

        // Four beats of 72 overflow a 9-bit accumulator.
        for (int b = 0; b < 4; b++) send_beat(16'hFFFF, 16'hFFFF, 8'h00, (b == 3), 0);
        finish_vec("ovf", 2);

        // Reset mid-vector discards the partial result.
        send_beat(16'hFFFF, 16'hFFFF, 8'h00, 1'b0, 0);
        send_beat(16'hFFFF, 16'hFFFF, 8'h00, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check("midrst_data", int'($signed(out_data)), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", int'(out_valid), 0);
        end
        send_beat(16'hFFFF, 16'hFFFF, 8'h00, 1'b1, 0);
        finish_vec("after_rst", 0);

        // Long vector drives the beat counter into saturation.
        rand_vec("long", 18);

        for (int v = 0; v < 30; v++) begin
            rand_vec("rand", $urandom_range(1, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
